// File: rtl/fft_pkg.sv
// fft_pkg: shared state type, sizing and sample helpers for the fft frame sequencer
package fft_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_N_2   = 5;
    typedef enum logic [2:0] {CLEAR, LOAD, START, COMPUTE, UNLOAD} seq_state_t;
    function automatic int n_points(input int n_2);
        return 2 ** n_2;
    endfunction
    function automatic logic [31:0] sext_sample(input logic [31:0] x, input int w);
        return 32'($signed(x << (32 - w)) >>> (32 - w));
    endfunction
endpackage

// File: rtl/fft_out_fifo.sv
// fft_out_fifo: two-entry result FIFO of {last, data} with occupancy count
module fft_out_fifo #(
    parameter int width = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [width-1:0] din,
    input  logic             pop,
    output logic [width-1:0] dout,
    output logic [1:0]       count
);
    logic [width-1:0] mem [2];
    logic wp, rp;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) mem[wp] <= din;
            wp    <= wp ^ push;
            rp    <= rp ^ pop;
            count <= count + 2'(push) - 2'(pop);
        end
    assign dout = mem[rp];
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: loads one frame into the fft engine, runs it and streams the results out
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int N_2   = DEF_N_2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*(width-N_2)-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*width-1:0]       out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     fft_reset,
    output logic                     fft_start,
    output logic                     fft_load,
    output logic [N_2-1:0]           fft_adr,
    output logic [2*width-1:0]       fft_rd,
    input  logic [2*width-1:0]       fft_wd,
    input  logic                     fft_done
);
    localparam int N  = n_points(N_2);
    localparam int CW = N_2 + 1;
    localparam int SW = width - N_2;
    seq_state_t state, state_nxt;
    logic [CW-1:0] ld_cnt, rd_cnt;
    logic inflight, inflight_last, ld_hs, issue, pop;
    logic [1:0] fifo_count;
    logic [2*width:0] head;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= CLEAR;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   state_nxt = LOAD;
            LOAD:    state_nxt = ld_hs && ld_cnt == CW'(N - 1) ? START : LOAD;
            START:   state_nxt = COMPUTE;
            COMPUTE: state_nxt = fft_done ? UNLOAD : COMPUTE;
            UNLOAD:  state_nxt = pop && head[2*width] ? CLEAR : UNLOAD;
            default: state_nxt = CLEAR;
        endcase
    end
    // a read may be issued into a slot that the current pop is freeing
    always_comb begin
        in_ready  = state == LOAD;
        ld_hs     = in_ready && in_valid;
        out_valid = state == UNLOAD && fifo_count != 2'd0;
        pop       = out_valid && out_ready;
        issue     = state == UNLOAD && rd_cnt != CW'(N) && 3'(fifo_count) + 3'(inflight) < 3'd2 + 3'(pop);
        busy      = state != LOAD;
        fft_reset = state == CLEAR;
        fft_start = state == START;
        fft_load  = ld_hs;
        fft_adr   = ld_hs ? ld_cnt[N_2-1:0] : issue ? rd_cnt[N_2-1:0] : '0;
        fft_rd    = ld_hs ? {width'(sext_sample(32'(in_data[2*SW-1:SW]), SW)),
                             width'(sext_sample(32'(in_data[SW-1:0]), SW))} : '0;
        out_data  = out_valid ? head[2*width-1:0] : '0;
        out_last  = out_valid && head[2*width];
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            ld_cnt        <= '0;
            rd_cnt        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            ld_cnt        <= state == CLEAR ? '0 : ld_cnt + CW'(ld_hs);
            rd_cnt        <= state == COMPUTE ? '0 : rd_cnt + CW'(issue);
            inflight      <= issue;
            inflight_last <= issue && rd_cnt == CW'(N - 1);
        end
    fft_out_fifo #(.width(2*width+1)) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (inflight),
        .din   ({inflight_last, fft_wd}),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count)
    );
endmodule
